// File: rtl/uart_frame_decoder.sv
// Byte-stream frame decoder: SYNC, CMD, LEN(0..4), payload, XOR checksum.
// Reports good frames and aborts (checksum, bad length, inter-byte timeout).
module uart_frame_decoder #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  cmd_out,
    output logic [31:0] payload_out,
    output logic [2:0]  len_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [7:0]       r_cmd;
    logic [7:0]       r_csum;
    logic [2:0]       r_len;
    logic [2:0]       r_idx;
    logic [31:0]      r_pay;
    logic             w_timeout;
    logic             w_good;
    logic             w_abort;
    logic [1:0]       w_code;

    // A byte arriving on the expiring cycle wins over the timeout.
    always_comb begin
        w_next    = r_state;
        w_good    = 1'b0;
        w_abort   = 1'b0;
        w_code    = 2'd0;
        w_timeout = (r_state != S_IDLE) && !rx_valid &&
                    (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_next  = S_IDLE;
            w_abort = 1'b1;
            w_code  = 2'd3;
        end else if (rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_byte == SYNC_BYTE) w_next = S_CMD;
                end
                S_CMD: w_next = S_LEN;
                S_LEN: begin
                    if (rx_byte == 8'd0) begin
                        w_next = S_CSUM;
                    end else if (rx_byte <= 8'd4) begin
                        w_next = S_PAYLOAD;
                    end else begin
                        w_next  = S_IDLE;
                        w_abort = 1'b1;
                        w_code  = 2'd2;
                    end
                end
                S_PAYLOAD: begin
                    if (r_idx + 3'd1 == r_len) w_next = S_CSUM;
                end
                S_CSUM: begin
                    w_next = S_IDLE;
                    if (rx_byte == r_csum) begin
                        w_good = 1'b1;
                    end else begin
                        w_abort = 1'b1;
                        w_code  = 2'd1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idle_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (rx_valid || (r_state == S_IDLE) || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end
        end
    end

    // Working copy of the frame being assembled; checksum accumulates from CMD on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd  <= '0;
            r_csum <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_pay  <= '0;
        end else if (rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    r_pay <= '0;
                    r_idx <= '0;
                end
                S_CMD: begin
                    r_cmd  <= rx_byte;
                    r_csum <= rx_byte;
                end
                S_LEN: begin
                    r_len  <= rx_byte[2:0];
                    r_csum <= r_csum ^ rx_byte;
                end
                S_PAYLOAD: begin
                    r_pay[{r_idx[1:0], 3'b000} +: 8] <= rx_byte;
                    r_idx  <= r_idx + 3'd1;
                    r_csum <= r_csum ^ rx_byte;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_out     <= '0;
            payload_out <= '0;
            len_out     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
            err_count   <= '0;
        end else begin
            frame_valid <= w_good;
            frame_err   <= w_abort;
            if (w_good) begin
                cmd_out     <= r_cmd;
                payload_out <= r_pay;
                len_out     <= r_len;
            end
            if (w_abort) begin
                err_code <= w_code;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Randomized and directed bench for uart_frame_decoder against a frame-level
// reference model that works on the collected byte list of the current frame.
module tb_uart_frame_decoder;

    localparam int         TO   = 8;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  cmd_out;
    logic [31:0] payload_out;
    logic [2:0]  len_out;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    uart_frame_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .cmd_out     (cmd_out),
        .payload_out (payload_out),
        .len_out     (len_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state: bytes of the frame in progress, idle run length.
    bq_t         m_buf;
    int          m_idle;
    logic [7:0]  m_cmd;
    logic [31:0] m_pay;
    logic [2:0]  m_len;
    logic        m_fv;
    logic        m_fe;
    logic [1:0]  m_code;
    logic [7:0]  m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_abort(input logic [1:0] c);
        m_fe   = 1'b1;
        m_code = c;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        m_buf.delete();
    endfunction

    function automatic void m_step(input logic v, input logic [7:0] b);
        int n;
        int len;
        logic [7:0] x;
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (m_buf.size() == 0) begin
            m_idle = 0;
            if (v && b == SYNC) m_buf.push_back(b);
        end else if (!v) begin
            m_idle++;
            if (m_idle == TO) m_abort(2'd3);
        end else begin
            m_idle = 0;
            m_buf.push_back(b);
            n = m_buf.size();
            len = int'(m_buf.size() >= 3 ? m_buf[2] : 8'd0);
            if (n == 3 && len > 4) begin
                m_abort(2'd2);
            end else if (n >= 3 && n == len + 4) begin
                x = 8'd0;
                for (int i = 1; i < n - 1; i++) x = x ^ m_buf[i];
                if (x == m_buf[n-1]) begin
                    m_cmd = m_buf[1];
                    m_len = 3'(len);
                    m_pay = '0;
                    for (int k = 0; k < len; k++) m_pay[8*k +: 8] = m_buf[3+k];
                    m_fv = 1'b1;
                    m_buf.delete();
                end else begin
                    m_abort(2'd1);
                end
            end
        end
    endfunction

    task automatic cmp_all();
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("frame_err",   32'(frame_err),   32'(m_fe));
        chk("cmd_out",     32'(cmd_out),     32'(m_cmd));
        chk("payload_out", payload_out,      m_pay);
        chk("len_out",     32'(len_out),     32'(m_len));
        chk("err_code",    32'(err_code),    32'(m_code));
        chk("err_count",   32'(err_count),   32'(m_cnt));
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        m_step(v, b);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        m_buf.delete();
        m_idle = 0;
        m_cmd = '0; m_pay = '0; m_len = '0;
        m_fv = 1'b0; m_fe = 1'b0; m_code = '0; m_cnt = '0;
        @(posedge clk);
        #1;
        cmp_all();
        rst = 1'b0;
    endtask

    task automatic send(input bq_t bs);
        foreach (bs[i]) step(1'b1, bs[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    initial begin
        bq_t         f;
        int          len;
        logic [7:0]  x;
        logic [7:0]  cmd;
        logic [7:0]  lb;

        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        @(posedge clk); #1;
        do_reset();

        // Good two-byte payload frame
        f = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
        send(f);
        chk("g1_fv",  32'(frame_valid), 32'd1);
        chk("g1_cmd", 32'(cmd_out),     32'h10);
        chk("g1_len", 32'(len_out),     32'd2);
        chk("g1_pay", payload_out,      32'h0000_4433);
        idle(1);
        chk("g1_fv_pulse", 32'(frame_valid), 32'd0);

        // Bad checksum keeps previous outputs
        f = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66};
        send(f);
        chk("ck_fe",   32'(frame_err), 32'd1);
        chk("ck_fv",   32'(frame_valid), 32'd0);
        chk("ck_code", 32'(err_code),  32'd1);
        chk("ck_cnt",  32'(err_count), 32'd1);
        chk("ck_cmd",  32'(cmd_out),   32'h10);
        chk("ck_pay",  payload_out,    32'h0000_4433);
        chk("ck_len",  32'(len_out),   32'd2);
        idle(1);

        // Zero-length frame
        f = '{8'hA5, 8'h20, 8'h00, 8'h20};
        send(f);
        chk("z_fv",  32'(frame_valid), 32'd1);
        chk("z_cmd", 32'(cmd_out),     32'h20);
        chk("z_len", 32'(len_out),     32'd0);
        chk("z_pay", payload_out,      32'd0);
        idle(1);

        // Bad length, then a clean frame
        f = '{8'hA5, 8'h10, 8'h05};
        send(f);
        chk("bl_fe",   32'(frame_err), 32'd1);
        chk("bl_code", 32'(err_code),  32'd2);
        f = '{8'hA5, 8'h20, 8'h00, 8'h20};
        send(f);
        chk("bl_next_fv", 32'(frame_valid), 32'd1);
        chk("bl_next_cmd", 32'(cmd_out),    32'h20);

        // Timeout after eight idle cycles
        f = '{8'hA5, 8'h10};
        send(f);
        idle(TO - 1);
        chk("to_early", 32'(frame_err), 32'd0);
        idle(1);
        chk("to_fe",   32'(frame_err), 32'd1);
        chk("to_code", 32'(err_code),  32'd3);
        chk("to_cnt",  32'(err_count), 32'd3);
        idle(2);

        // Byte on the eighth idle cycle wins
        f = '{8'hA5, 8'h10};
        send(f);
        idle(TO - 1);
        step(1'b1, 8'h00);
        chk("tw_fe",  32'(frame_err), 32'd0);
        step(1'b1, 8'h10);
        chk("tw_fv",  32'(frame_valid), 32'd1);
        chk("tw_cnt", 32'(err_count),   32'd3);

        // Randomized frames: noise, bad lengths, corrupt checksums, long gaps
        for (int fr = 0; fr < 250; fr++) begin
            if ($urandom_range(0, 3) == 0) step(1'b1, 8'($urandom));
            cmd = 8'($urandom);
            len = $urandom_range(0, 7);
            lb  = (len <= 4) ? 8'(len) : 8'($urandom_range(5, 255));
            f.delete();
            f.push_back(SYNC);
            f.push_back(cmd);
            f.push_back(lb);
            x = cmd ^ lb;
            if (lb <= 8'd4) begin
                for (int k = 0; k < int'(lb); k++) begin
                    f.push_back(8'($urandom));
                    x = x ^ f[f.size()-1];
                end
                if ($urandom_range(0, 5) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
                f.push_back(x);
            end
            foreach (f[i]) begin
                if ($urandom_range(0, 19) == 0) idle($urandom_range(5, 10));
                else idle($urandom_range(0, 1));
                step(1'b1, f[i]);
            end
        end
        idle(TO + 1);

        // Saturate the error counter, then reset mid-frame
        for (int fr = 0; fr < 300; fr++) begin
            f = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66};
            send(f);
        end
        chk("sat_cnt", 32'(err_count), 32'd255);
        f = '{8'hA5, 8'h10, 8'h02, 8'h33};
        send(f);
        do_reset();
        chk("rst_cnt",  32'(err_count),   32'd0);
        chk("rst_cmd",  32'(cmd_out),     32'd0);
        chk("rst_pay",  payload_out,      32'd0);
        chk("rst_len",  32'(len_out),     32'd0);
        chk("rst_code", 32'(err_code),    32'd0);
        chk("rst_fe",   32'(frame_err),   32'd0);
        chk("rst_fv",   32'(frame_valid), 32'd0);
        // Remainder of the interrupted frame must not decode or error
        f = '{8'h44, 8'h65};
        send(f);
        idle(TO + 2);
        chk("post_rst_cnt", 32'(err_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, the maximum number of idle clocks allowed between bytes inside a frame.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port rx_byte, input, 8 bits: received byte from the UART receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_byte.
REQ-007 SHALL have port cmd_out, output, 8 bits: command byte of the last good frame.
REQ-008 SHALL have port payload_out, output, 32 bits: payload of the last good frame, first byte in [7:0].
REQ-009 SHALL have port len_out, output, 3 bits: payload length of the last good frame.
REQ-010 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a good frame completes.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-012 SHALL have port err_code, output, 2 bits: cause of the last abort (1 checksum, 2 bad length, 3 timeout).
REQ-013 SHALL have port err_count, output, 8 bits: saturating count of aborted frames.

Function
REQ-014 SHALL accept the frame format SYNC_BYTE, CMD, LEN (0..4), LEN payload bytes, CSUM, where CSUM = XOR of CMD, LEN and all payload bytes.
REQ-015 SHALL implement the FSM states IDLE, CMD, LEN, PAYLOAD and CSUM, advancing at most one state per accepted byte (rx_valid=1).
REQ-016 SHALL, in IDLE, move to CMD on a byte equal to SYNC_BYTE and silently discard any other byte, with no error.
REQ-017 SHALL, in CMD, latch the byte as the command and go to LEN, with no check against SYNC_BYTE.
REQ-018 SHALL, in LEN, go to CSUM if LEN=0, to PAYLOAD if LEN is 1..4, and otherwise abort with err_code=2 and return to IDLE.
REQ-019 SHALL, in PAYLOAD, store byte k at payload bits [8k+7:8k] and go to CSUM after LEN bytes.
REQ-020 SHALL, in CSUM, on a match update cmd_out, payload_out (unused bytes = 0) and len_out, then pulse frame_valid; on a mismatch abort with err_code=1; in both cases return to IDLE.
REQ-021 SHALL assert frame_valid and frame_err in the cycle after the rx_valid that completes or aborts the frame (latency 1).
REQ-022 SHALL hold cmd_out, payload_out and len_out stable except when updated by a good frame.
REQ-023 SHALL, in any state other than IDLE, count consecutive cycles with rx_valid=0 and clear the count on every accepted byte.
REQ-024 SHALL, when the idle count reaches TIMEOUT_CYCLES, abort with err_code=3 and return to IDLE.
REQ-025 SHALL give rx_valid priority when it arrives on the cycle the count would expire: the byte is processed and no timeout occurs.
REQ-026 SHALL, on each abort, increment err_count, saturating at 255.
REQ-027 SHALL never assert frame_valid and frame_err in the same cycle.
REQ-028 SHALL NOT treat the byte that causes an abort as a new sync byte; the next frame needs a fresh SYNC_BYTE.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set state to IDLE and the timeout counter, cmd_out, payload_out, len_out, frame_valid, frame_err, err_code and err_count to 0.
REQ-030 SHALL, if reset arrives mid-frame, discard the partial frame without asserting frame_err.

Verification
REQ-031 SHALL be tested with bytes A5 10 02 33 44 65: expect frame_valid for one cycle, cmd_out=10, len_out=2 and payload_out=00004433.
REQ-032 SHALL be tested with bytes A5 20 00 20: expect frame_valid, len_out=0 and payload_out=0.
REQ-033 SHALL be tested with bytes A5 10 02 33 44 66: expect frame_err, err_code=1, err_count=1 and outputs unchanged.
REQ-034 SHALL be tested with bytes A5 10 05: expect frame_err, err_code=2, then the following A5 20 00 20 decodes correctly.
REQ-035 SHALL be tested with TIMEOUT_CYCLES=8 and bytes A5 10 followed by 8 idle cycles: expect frame_err with err_code=3; with a byte on the 8th cycle instead, expect no error.
REQ-036 SHALL be tested with 300 bad-checksum frames: expect err_count=255, then rst=1 mid-frame clears all outputs.
